// File: rtl/counter.sv
// -----------------------------------------------------------------------------
// counter
//   Two-digit BCD up-counter that wraps to 00 after MODULUS-1.
//   The count runs 0..MODULUS-1, with value V = 10*out_ten + out_one.
//
// Parameters
//   MODULUS  count wrap modulus, legal range 2..100 (default 100)
//
// Ports
//   clk      system clock; all state changes on the rising edge
//   reset    synchronous active-high reset; forces 00 and wins over counting
//   out_ten  BCD tens digit (0..9), driven straight from a register
//   out_one  BCD ones digit (0..9), driven straight from a register
// -----------------------------------------------------------------------------
module counter #(
   parameter int MODULUS = 100
) (
   input  logic       clk,
   input  logic       reset,
   output logic [3:0] out_ten,
   output logic [3:0] out_one
);

   // Last value before the wrap, split into its BCD digits.
   localparam logic [3:0] WRAP_TEN = 4'((MODULUS - 1) / 10);
   localparam logic [3:0] WRAP_ONE = 4'((MODULUS - 1) % 10);

   // Declaration initialisers give a defined 00 at power-up even if reset
   // never arrives.
   logic [3:0] ten_q = 4'd0;
   logic [3:0] one_q = 4'd0;
   logic [3:0] ten_d;
   logic [3:0] one_d;
   logic       at_wrap;
   logic       one_carry;

   assign at_wrap   = (ten_q == WRAP_TEN) && (one_q == WRAP_ONE);
   assign one_carry = (one_q >= 4'd9);

   always_comb begin
      ten_d = ten_q;
      one_d = one_q;
      if (at_wrap) begin
         ten_d = 4'd0;
         one_d = 4'd0;
      end else if (one_carry) begin
         // V < MODULUS <= 100, so the tens digit never needs its own rollover.
         one_d = 4'd0;
         ten_d = ten_q + 4'd1;
      end else begin
         one_d = one_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ten_q <= 4'd0;
         one_q <= 4'd0;
      end else begin
         ten_q <= ten_d;
         one_q <= one_d;
      end
   end

   assign out_ten = ten_q;
   assign out_one = one_q;

endmodule

// File: tb/tb_counter.sv
module tb_counter;

   logic       clk = 1'b0;
   logic       reset_a = 1'b0;
   logic       reset_b = 1'b1;
   logic [3:0] ten_a, one_a, ten_b, one_b;

   int checks = 0;
   int errors = 0;
   int exp_a;
   int bad_digits;

   always #5 clk = ~clk;

   counter #(.MODULUS(100)) u_dut_a (
      .clk     (clk),
      .reset   (reset_a),
      .out_ten (ten_a),
      .out_one (one_a)
   );

   counter #(.MODULUS(60)) u_dut_b (
      .clk     (clk),
      .reset   (reset_b),
      .out_ten (ten_b),
      .out_one (one_b)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int val_a();
      if ($isunknown({ten_a, one_a})) return -1;
      return 10 * int'(ten_a) + int'(one_a);
   endfunction

   function automatic int val_b();
      if ($isunknown({ten_b, one_b})) return -1;
      return 10 * int'(ten_b) + int'(one_b);
   endfunction

   // One rising edge, then sample on the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // Power-up with reset never asserted.
      #1 chk("pwrup_val", val_a(), 0);
      for (int i = 1; i <= 50; i++) begin
         step();
         chk("pwrup_cnt", val_a(), i);
      end
      chk("pwrup_ten", int'(ten_a), 5);
      chk("pwrup_one", int'(one_a), 0);

      // Reset held for 50 edges.
      reset_a = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step();
         chk("rst_hold", val_a(), 0);
      end

      // Release: first edge gives 01, then count through the first carry.
      reset_a = 1'b0;
      step();
      chk("release", val_a(), 1);
      for (int i = 2; i <= 9; i++) begin
         step();
         chk("to_09", val_a(), i);
      end
      step();
      chk("carry_ten", int'(ten_a), 1);
      chk("carry_one", int'(one_a), 0);

      // 250 edges across two wraps, digit range watched throughout.
      exp_a = 10;
      bad_digits = 0;
      for (int i = 0; i < 250; i++) begin
         step();
         exp_a = (exp_a + 1) % 100;
         chk("run250", val_a(), exp_a);
         if (ten_a > 4'd9 || one_a > 4'd9) bad_digits++;
      end
      chk("digit_range", bad_digits, 0);

      // From 60 up to 99, then reset priority at the wrap edge.
      for (int i = 61; i <= 99; i++) begin
         step();
         chk("to_99", val_a(), i);
      end
      reset_a = 1'b1;
      step();
      chk("rst_at_99", val_a(), 0);
      reset_a = 1'b0;
      step();
      chk("rel_after_99", val_a(), 1);

      // Reset priority mid-carry (ones = 9).
      for (int i = 2; i <= 9; i++) step();
      chk("at_09", val_a(), 9);
      reset_a = 1'b1;
      step();
      chk("rst_mid_carry", val_a(), 0);
      reset_a = 1'b0;
      step();
      chk("rel_mid_carry", val_a(), 1);

      // Reset pulse entirely between edges: ignored.
      reset_a = 1'b1;
      #1 chk("hold_between", val_a(), 1);
      #1 reset_a = 1'b0;
      step();
      chk("glitch_ignored", val_a(), 2);

      // Reset asserted mid-cycle: outputs hold until the edge.
      reset_a = 1'b1;
      #2 chk("hold_until_edge", val_a(), 2);
      step();
      chk("rst_at_edge", val_a(), 0);
      reset_a = 1'b0;

      // MODULUS = 60 instance, held in reset until now.
      chk("m60_reset", val_b(), 0);
      reset_b = 1'b0;
      for (int i = 1; i <= 59; i++) begin
         step();
         chk("m60_cnt", val_b(), i);
      end
      chk("m60_ten", int'(ten_b), 5);
      chk("m60_one", int'(one_b), 9);
      step();
      chk("m60_wrap", val_b(), 0);
      step();
      chk("m60_after", val_b(), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter MODULUS, default 100, count wrap modulus; legal range 2..100; the count runs 0..MODULUS-1.
REQ-002 clk  input  1  single clock; all state updates on rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 out_ten  output  4  BCD tens digit of current count, 0..9.
REQ-005 out_one  output  4  BCD ones digit of current count, 0..9.
REQ-006 Outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Function
REQ-007 The block SHALL be a two-digit decimal (BCD) up-counter with value V = 10*out_ten + out_one.
REQ-008 On each rising edge with reset=0, V SHALL advance by exactly 1.
REQ-009 Ones digit behaviour: 0..8 -> +1; 9 -> 0 with carry into the tens digit on the same edge.
REQ-010 Tens digit behaviour: +1 only on a ones carry, with no separate tens rollover since V < 100.
REQ-011 Wrap: when V = MODULUS-1 at an edge with reset=0, the next V SHALL be 00 (both digits 0 on the same edge).
REQ-012 For the default MODULUS the sequence SHALL be 00,01,...,09,10,...,99,00,... with no skipped or repeated value.
REQ-013 Latency: the new value SHALL be visible on the outputs immediately after the rising edge that produced it.
REQ-014 Neither digit SHALL ever take a value in 10..15, including after wrap or reset.
REQ-015 Power-up: both digit registers SHALL initialise to 0 before any reset, so counting from 00 is defined even if reset is never asserted.
REQ-016 Between clock edges the outputs SHALL hold their value regardless of reset transitions.

Reset
REQ-017 Reset value: at a rising edge with reset=1, out_ten SHALL become 0 and out_one SHALL become 0.
REQ-018 Reset SHALL take priority over counting, including at the wrap edge (V = MODULUS-1) and mid-carry (out_one = 9).
REQ-019 While reset stays high the outputs SHALL stay 00 on every edge.
REQ-020 Release: on the first rising edge after reset falls (reset=0 sampled), V SHALL become 01.
REQ-021 Asserting reset between edges SHALL have no effect until the next rising edge (synchronous behaviour).

Verification
REQ-022 Power-up with reset=0 for 50 rising edges -> out_ten=5, out_one=0 (V=50); after each edge V equals the edge count.
REQ-023 Continue with reset=1 for 50 rising edges -> outputs 00 after the first edge and held at 00 for all remaining edges.
REQ-024 Count from 00 for 9 edges, then 1 more edge -> 09 then 10 (ones carry sets out_one=0 and out_tens=1 on the same edge).
REQ-025 Count to 99, then 1 more edge -> 00; check that no 10..15 digit value appears at any point over 250 edges.
REQ-026 Assert reset at V=99, hold for 1 edge, then release -> 00 after the reset edge, 01 after the next edge.
REQ-027 MODULUS=60: count 59 edges then 1 more -> 59 then 00.
